// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared digit width, default moduli and helpers for the
//               stopwatch seconds counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int DIGIT_W      = 4;
  localparam int ONES_MOD_DEF = 10;
  localparam int TENS_MOD_DEF = 6;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Saturate a loaded value to the digit's last legal value.
  function automatic digit_t clamp_digit(input digit_t v, input digit_t last);
    return (v > last) ? last : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_digit.sv
// ============================================================================
// Module      : mod_n_digit
// Description : One modulo-MOD counting digit with optional parallel load and
//               terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = ONES_MOD_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   active,
  input  logic   en,
  input  logic   load,
  input  digit_t load_val,
  output digit_t value,
  output logic   tc
);

  localparam digit_t LAST = digit_t'(MOD - 1);

  digit_t value_q;
  digit_t value_d;

  // An illegal value is scrubbed on any un-paused tick, even when this digit
  // is not being stepped, so a corrupted tens digit cannot linger.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = clamp_digit(load_val, LAST);
    end else if (active && (value_q > LAST)) begin
      value_d = '0;
    end else if (en) begin
      value_d = (value_q == LAST) ? '0 : value_q + digit_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign tc    = (value_q == LAST);

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module      : stopwatch_counter
// Description : Two-digit cascaded seconds counter (mod-ONES_MOD ones feeding
//               mod-TENS_MOD tens) with pause and cascade carries.
//               Define STOPWATCH_COUNTER_LOAD_EN to add a parallel load port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int ONES_MOD = ONES_MOD_DEF,
  parameter int TENS_MOD = TENS_MOD_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PAUSE,
`ifdef STOPWATCH_COUNTER_LOAD_EN
  input  logic               LOAD,
  input  logic [DIGIT_W-1:0] LOAD_ONES,
  input  logic [DIGIT_W-1:0] LOAD_TENS,
`endif
  output logic               CARRY10,
  output logic               CARRY6,
  output logic [DIGIT_W-1:0] ONES,
  output logic [DIGIT_W-1:0] TENS
);

  logic   load_en;
  digit_t load_ones;
  digit_t load_tens;
  logic   count_en;
  logic   ones_tc;
  logic   tens_tc;
  digit_t ones_val;
  digit_t tens_val;

`ifdef STOPWATCH_COUNTER_LOAD_EN
  assign load_en   = LOAD;
  assign load_ones = LOAD_ONES;
  assign load_tens = LOAD_TENS;
`else
  assign load_en   = 1'b0;
  assign load_ones = '0;
  assign load_tens = '0;
`endif

  assign count_en = !PAUSE;

  mod_n_digit #(
    .MOD      (ONES_MOD)
  ) u_ones (
    .clk      (CLK),
    .rst      (RESET),
    .active   (count_en),
    .en       (count_en),
    .load     (load_en),
    .load_val (load_ones),
    .value    (ones_val),
    .tc       (ones_tc)
  );

  mod_n_digit #(
    .MOD      (TENS_MOD)
  ) u_tens (
    .clk      (CLK),
    .rst      (RESET),
    .active   (count_en),
    .en       (count_en && ones_tc),
    .load     (load_en),
    .load_val (load_tens),
    .value    (tens_val),
    .tc       (tens_tc)
  );

  assign CARRY10 = count_en && ones_tc;
  assign CARRY6  = CARRY10 && tens_tc;
  assign ONES    = ones_val;
  assign TENS    = tens_val;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Directed self-checking bench for stopwatch_counter; the load
//               test is included when STOPWATCH_COUNTER_LOAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stopwatch_counter;

  logic       CLK;
  logic       RESET;
  logic       PAUSE;
  logic       CARRY10;
  logic       CARRY6;
  logic [3:0] ONES;
  logic [3:0] TENS;
`ifdef STOPWATCH_COUNTER_LOAD_EN
  logic       LOAD;
  logic [3:0] LOAD_ONES;
  logic [3:0] LOAD_TENS;
`endif

  int checks = 0;
  int errors = 0;

  stopwatch_counter #(
    .ONES_MOD  (10),
    .TENS_MOD  (6)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PAUSE     (PAUSE),
`ifdef STOPWATCH_COUNTER_LOAD_EN
    .LOAD      (LOAD),
    .LOAD_ONES (LOAD_ONES),
    .LOAD_TENS (LOAD_TENS),
`endif
    .CARRY10   (CARRY10),
    .CARRY6    (CARRY6),
    .ONES      (ONES),
    .TENS      (TENS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    PAUSE = 1'b0;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ONES !== 4'd0) begin errors++; $display("FAIL reset_ones got %0d want 0", ONES); end
    checks++; if (TENS !== 4'd0) begin errors++; $display("FAIL reset_tens got %0d want 0", TENS); end
    checks++; if (CARRY10 !== 1'b0) begin errors++; $display("FAIL reset_c10 got %b want 0", CARRY10); end
    checks++; if (CARRY6 !== 1'b0) begin errors++; $display("FAIL reset_c6 got %b want 0", CARRY6); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (CARRY10 !== (i == 9)) begin
        errors++; $display("FAIL free_c10 step %0d got %b want %b", i, CARRY10, (i == 9));
      end
      tick();
    end
    checks++; if (ONES !== 4'd0) begin errors++; $display("FAIL free_ones got %0d want 0", ONES); end
    checks++; if (TENS !== 4'd1) begin errors++; $display("FAIL free_tens got %0d want 1", TENS); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 59; i++) tick();
    checks++; if (ONES !== 4'd9) begin errors++; $display("FAIL wrap59_ones got %0d want 9", ONES); end
    checks++; if (TENS !== 4'd5) begin errors++; $display("FAIL wrap59_tens got %0d want 5", TENS); end
    checks++; if (CARRY10 !== 1'b1) begin errors++; $display("FAIL wrap59_c10 got %b want 1", CARRY10); end
    checks++; if (CARRY6 !== 1'b1) begin errors++; $display("FAIL wrap59_c6 got %b want 1", CARRY6); end
    tick();
    checks++; if (ONES !== 4'd0 || TENS !== 4'd0) begin errors++; $display("FAIL wrap60_state got %0d%0d want 00", TENS, ONES); end
    checks++; if (CARRY10 !== 1'b0 || CARRY6 !== 1'b0) begin errors++; $display("FAIL wrap60_carry got %b%b want 00", CARRY10, CARRY6); end
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    PAUSE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ONES !== 4'd9 || TENS !== 4'd0 || CARRY10 !== 1'b0 || CARRY6 !== 1'b0) begin
        errors++; $display("FAIL pause_hold step %0d got %0d%0d c10=%b c6=%b want 09 c10=0 c6=0", i, TENS, ONES, CARRY10, CARRY6);
      end
    end
    PAUSE = 1'b0;
    #1;
    checks++; if (CARRY10 !== 1'b1) begin errors++; $display("FAIL unpause_c10 got %b want 1", CARRY10); end
    checks++; if (CARRY6 !== 1'b0) begin errors++; $display("FAIL unpause_c6 got %b want 0", CARRY6); end
    tick();
    checks++; if (ONES !== 4'd0 || TENS !== 4'd1) begin errors++; $display("FAIL unpause_step got %0d%0d want 10", TENS, ONES); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 37; i++) tick();
    checks++; if (ONES !== 4'd7 || TENS !== 4'd3) begin errors++; $display("FAIL mid_pre got %0d%0d want 37", TENS, ONES); end
    RESET = 1'b1;
    PAUSE = 1'b1;
    tick();
    RESET = 1'b0;
    PAUSE = 1'b0;
    #1;
    checks++; if (ONES !== 4'd0 || TENS !== 4'd0) begin errors++; $display("FAIL mid_reset got %0d%0d want 00", TENS, ONES); end
    checks++; if (CARRY10 !== 1'b0 || CARRY6 !== 1'b0) begin errors++; $display("FAIL mid_carry got %b%b want 00", CARRY10, CARRY6); end
  endtask

  // Reset at 59 must give 00 with no carry, then pause toggled every tick
  // must step exactly once per un-paused edge.
  task automatic test_back_to_back();
    int exp_cnt;
    do_reset();
    for (int i = 0; i < 59; i++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    checks++; if (ONES !== 4'd0 || TENS !== 4'd0 || CARRY10 !== 1'b0 || CARRY6 !== 1'b0) begin
      errors++; $display("FAIL reset59 got %0d%0d c10=%b c6=%b want 00 c10=0 c6=0", TENS, ONES, CARRY10, CARRY6);
    end
    exp_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      PAUSE = (i % 3) == 1;
      #1;
      checks++;
      if (CARRY10 !== (!PAUSE && (exp_cnt % 10) == 9)) begin
        errors++; $display("FAIL toggle_c10 step %0d got %b want %b", i, CARRY10, (!PAUSE && (exp_cnt % 10) == 9));
      end
      tick();
      if (!PAUSE) exp_cnt = (exp_cnt + 1) % 60;
      checks++;
      if (ONES !== 4'(exp_cnt % 10) || TENS !== 4'(exp_cnt / 10)) begin
        errors++; $display("FAIL toggle_state step %0d got %0d%0d want %0d", i, TENS, ONES, exp_cnt);
      end
    end
    PAUSE = 1'b0;
  endtask

`ifdef STOPWATCH_COUNTER_LOAD_EN
  task automatic test_load();
    do_reset();
    LOAD = 1'b1; LOAD_ONES = 4'd8; LOAD_TENS = 4'd5;
    tick();
    LOAD = 1'b0;
    #1;
    checks++; if (ONES !== 4'd8 || TENS !== 4'd5) begin errors++; $display("FAIL load_state got %0d%0d want 58", TENS, ONES); end
    tick();
    checks++; if (ONES !== 4'd9 || TENS !== 4'd5 || CARRY6 !== 1'b1) begin
      errors++; $display("FAIL load_step got %0d%0d c6=%b want 59 c6=1", TENS, ONES, CARRY6);
    end
    PAUSE = 1'b1; LOAD = 1'b1; LOAD_ONES = 4'd14; LOAD_TENS = 4'd9;
    tick();
    LOAD = 1'b0; PAUSE = 1'b0;
    #1;
    checks++; if (ONES !== 4'd9 || TENS !== 4'd5) begin errors++; $display("FAIL load_clamp got %0d%0d want 59", TENS, ONES); end
  endtask
`endif

  initial begin
    RESET = 1'b0;
    PAUSE = 1'b0;
`ifdef STOPWATCH_COUNTER_LOAD_EN
    LOAD = 1'b0; LOAD_ONES = 4'd0; LOAD_TENS = 4'd0;
`endif
    test_reset();
    test_free_run();
    test_full_wrap();
    test_pause();
    test_reset_mid();
    test_back_to_back();
`ifdef STOPWATCH_COUNTER_LOAD_EN
    test_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
